// File: rtl/reg_write_arbiter_if.sv
// Writeback request bus between requesters and reg_write_arbiter.
// Signals: req_valid/req_addr/req_data/wr_hold from requesters, req_ready back.
interface reg_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*4-1:0]  req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_hold;

    modport master (
        output req_valid, req_addr, req_data, wr_hold,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, wr_hold,
        output req_ready
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: shares WE3/WA3/WD3 among NREQ writers,
// steers R15 writes to the PC port, and tracks pending writes for RAW stalls.
// Ports: sys_clk, sys_rst_n (async, active-high), bus (requests/grants),
//   rf_we/rf_wa/rf_wd, pc_we/pc_wd, claim_valid/claim_addr, busy_mask, err_r14.
// Build option: define RR_ARB_EN for round-robin, else fixed priority.
module reg_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    reg_write_arbiter_if.slave   bus,
    output logic                 rf_we,
    output logic [3:0]           rf_wa,
    output logic [DW-1:0]        rf_wd,
    output logic                 pc_we,
    output logic [DW-1:0]        pc_wd,
    input  logic                 claim_valid,
    input  logic [3:0]           claim_addr,
    output logic [15:0]          busy_mask,
    output logic                 err_r14
);

    logic [NREQ-1:0] grant;
    logic            accept;
    logic [3:0]      sel_addr;
    logic [DW-1:0]   sel_data;
    logic [15:0]     busy_nxt;

`ifdef RR_ARB_EN
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // Search starts one past the last winner; ptr itself is checked last.
    always_comb begin
        grant   = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && bus.req_valid[i] &&
                    i == (int'(ptr) + k) % NREQ) begin
                    grant[i] = 1'b1;
                    gnt_idx  = PW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            ptr <= PW'(NREQ - 1);
        end else if (accept) begin
            ptr <= gnt_idx;
        end
    end
`else
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    assign bus.req_ready = (sys_rst_n || bus.wr_hold) ? '0 : grant;
    assign accept        = |bus.req_ready;

    // req_ready is one-hot, so OR-ing the selected lanes is a plain mux.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) begin
                sel_addr = sel_addr | bus.req_addr[4*i +: 4];
                sel_data = sel_data | bus.req_data[DW*i +: DW];
            end
        end
    end

    // A same-cycle claim wins over the clear: a new writer is pending.
    always_comb begin
        busy_nxt = busy_mask;
        if (accept) begin
            busy_nxt[sel_addr] = 1'b0;
        end
        if (claim_valid && claim_addr != 4'd14) begin
            busy_nxt[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            pc_we     <= 1'b0;
            pc_wd     <= '0;
            busy_mask <= '0;
            err_r14   <= 1'b0;
        end else begin
            rf_we     <= accept && (sel_addr < 4'd14);
            pc_we     <= accept && (sel_addr == 4'd15);
            busy_mask <= busy_nxt;
            if (accept && sel_addr < 4'd14) begin
                rf_wa <= sel_addr;
                rf_wd <= sel_data;
            end
            if (accept && sel_addr == 4'd15) begin
                pc_wd <= sel_data;
            end
            if (accept && sel_addr == 4'd14) begin
                err_r14 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed vector bench for reg_write_arbiter.
// Table of single-cycle vectors plus sequences for reset and arbitration.
module tb_reg_write_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;

    logic        clk;
    logic        rst;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic        claim_valid;
    logic [3:0]  claim_addr;
    logic [15:0] busy_mask;
    logic        err_r14;

    int n_vec;
    int n_bad;

    reg_write_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    reg_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst),
        .bus         (bus),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .pc_we       (pc_we),
        .pc_wd       (pc_wd),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .busy_mask   (busy_mask),
        .err_r14     (err_r14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        int          r;
        logic [3:0]  a;
        logic [31:0] d;
        logic        hold;
        logic        cv;
        logic [3:0]  ca;
        logic [2:0]  e_rdy;
        logic        e_rfwe;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_pcwe;
        logic [31:0] e_pcwd;
        logic [15:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t tv[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_one(input logic v, input int r, input logic [3:0] a,
                             input logic [31:0] d);
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        if (v) begin
            bus.req_valid[r]       = 1'b1;
            bus.req_addr[4*r +: 4] = a;
            bus.req_data[32*r +: 32] = d;
        end
    endtask

    task automatic idle_inputs();
        drive_one(1'b0, 0, 4'd0, 32'd0);
        bus.wr_hold = 1'b0;
        claim_valid = 1'b0;
        claim_addr  = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();

        //    v  r  a   d             h  cv ca  rdy   rfwe wa  wd           pcwe pcwd    busy      err
        tv[0]  = '{1, 0, 3, 32'h12345678, 0, 0, 0, 3'b001, 1, 3, 32'h12345678, 0, 32'h0, 16'h0000, 0};
        tv[1]  = '{0, 0, 0, 32'h0,        0, 0, 0, 3'b000, 0, 3, 32'h12345678, 0, 32'h0, 16'h0000, 0};
        tv[2]  = '{0, 0, 0, 32'h0,        0, 1, 5, 3'b000, 0, 3, 32'h12345678, 0, 32'h0, 16'h0020, 0};
        tv[3]  = '{0, 0, 0, 32'h0,        0, 0, 0, 3'b000, 0, 3, 32'h12345678, 0, 32'h0, 16'h0020, 0};
        tv[4]  = '{0, 0, 0, 32'h0,        0, 0, 0, 3'b000, 0, 3, 32'h12345678, 0, 32'h0, 16'h0020, 0};
        tv[5]  = '{1, 1, 5, 32'hAAAA0005, 0, 1, 5, 3'b010, 1, 5, 32'hAAAA0005, 0, 32'h0, 16'h0020, 0};
        tv[6]  = '{1, 2, 5, 32'h55550005, 0, 0, 0, 3'b100, 1, 5, 32'h55550005, 0, 32'h0, 16'h0000, 0};
        tv[7]  = '{0, 0, 0, 32'h0,        0, 1, 15, 3'b000, 0, 5, 32'h55550005, 0, 32'h0, 16'h8000, 0};
        tv[8]  = '{1, 0, 15, 32'hB5,      0, 0, 0, 3'b001, 0, 5, 32'h55550005, 1, 32'hB5, 16'h0000, 0};
        tv[9]  = '{0, 0, 0, 32'h0,        0, 1, 14, 3'b000, 0, 5, 32'h55550005, 0, 32'hB5, 16'h0000, 0};
        tv[10] = '{1, 2, 14, 32'hDEAD,    0, 0, 0, 3'b100, 0, 5, 32'h55550005, 0, 32'hB5, 16'h0000, 1};
        tv[11] = '{1, 1, 7, 32'h77,       1, 0, 0, 3'b000, 0, 5, 32'h55550005, 0, 32'hB5, 16'h0000, 1};
        tv[12] = '{1, 1, 7, 32'h77,       0, 0, 0, 3'b010, 1, 7, 32'h77,       0, 32'hB5, 16'h0000, 1};
        tv[13] = '{1, 0, 0, 32'h0,        0, 1, 2, 3'b001, 1, 0, 32'h0,        0, 32'hB5, 16'h0004, 1};
        tv[14] = '{1, 2, 2, 32'hC2,       0, 0, 0, 3'b100, 1, 2, 32'hC2,       0, 32'hB5, 16'h0000, 1};

        // Reset state, with a requester valid: no grant while in reset.
        @(negedge clk);
        drive_one(1'b1, 0, 4'd3, 32'h1);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rf_we", 32'(rf_we), 32'h0);
        check("rst_rf_wa", 32'(rf_wa), 32'h0);
        check("rst_rf_wd", rf_wd, 32'h0);
        check("rst_pc_we", 32'(pc_we), 32'h0);
        check("rst_pc_wd", pc_wd, 32'h0);
        check("rst_busy", 32'(busy_mask), 32'h0);
        check("rst_err", 32'(err_r14), 32'h0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive_one(tv[i].v, tv[i].r, tv[i].a, tv[i].d);
            bus.wr_hold = tv[i].hold;
            claim_valid = tv[i].cv;
            claim_addr  = tv[i].ca;
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tv[i].e_rfwe));
            check($sformatf("v%0d_rf_wa", i), 32'(rf_wa), 32'(tv[i].e_wa));
            check($sformatf("v%0d_rf_wd", i), rf_wd, tv[i].e_wd);
            check($sformatf("v%0d_pc_we", i), 32'(pc_we), 32'(tv[i].e_pcwe));
            check($sformatf("v%0d_pc_wd", i), pc_wd, tv[i].e_pcwd);
            check($sformatf("v%0d_busy", i), 32'(busy_mask), 32'(tv[i].e_busy));
            check($sformatf("v%0d_err", i), 32'(err_r14), 32'(tv[i].e_err));
            @(negedge clk);
        end

        // Reset asserted in the cycle after an accept.
        idle_inputs();
        claim_valid = 1'b1;
        claim_addr  = 4'd4;
        @(negedge clk);
        idle_inputs();
        drive_one(1'b1, 0, 4'd9, 32'h99);
        @(posedge clk);
        #1;
        check("pre_rst_rf_we", 32'(rf_we), 32'h1);
        check("pre_rst_busy", 32'(busy_mask), 32'h0010);
        drive_one(1'b1, 1, 4'd6, 32'h66);
        rst = 1'b1;
        #1;
        check("mid_rst_rf_we", 32'(rf_we), 32'h0);
        check("mid_rst_busy", 32'(busy_mask), 32'h0);
        check("mid_rst_err", 32'(err_r14), 32'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'b010);
        @(posedge clk);
        #1;
        check("post_rst_rf_we", 32'(rf_we), 32'h1);
        check("post_rst_rf_wa", 32'(rf_wa), 32'h6);
        check("post_rst_rf_wd", rf_wd, 32'h66);
        idle_inputs();

        // All three requesters held valid from a fresh reset.
        do_reset();
        bus.req_valid = 3'b111;
        bus.req_addr  = {4'd10, 4'd9, 4'd8};
        bus.req_data  = {32'hC0, 32'hB0, 32'hA0};
        for (int c = 0; c < 4; c++) begin
            logic [2:0] e;
`ifdef RR_ARB_EN
            e = 3'b001 << (c % 3);
`else
            e = 3'b001;
`endif
            #1;
            check($sformatf("arb%0d_ready", c), 32'(bus.req_ready), 32'(e));
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
